ibm_src_arb: RTL and testbench
==============================

# ibm_src_arb

Packet-granular input arbiter in front of the ibm stage. It merges the two packet sources, the external port and the CPU path, into the single 134-bit data/valid stream that ibm consumes. Sources alternate round-robin. A new packet starts only when the downstream buffer manager reports enough free buffer IDs. Each source is a pair of first-word-fall-through (FWFT) FIFOs: one for data words, one for per-packet valid flags. Arbiter output feeds ibm's in_ibm_data / in_ibm_data_wr / in_ibm_valid / in_ibm_valid_wr.

## Interface
- MIN_FREE, default 6'd2: minimum in_arb_free_count required to start a packet.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_port_data  in  134  port data FIFO head word (FWFT); [133:132]: 01 head, 11 middle, 10 tail
- in_port_data_empty  in  1  port data FIFO empty
- out_port_data_rd  out  1  pop port data FIFO (combinational)
- in_port_valid  in  1  port valid FIFO head (1 = keep packet, 0 = drop)
- in_port_valid_empty  in  1  port valid FIFO empty; non-empty means ≥1 complete packet queued
- out_port_valid_rd  out  1  pop port valid FIFO (combinational)
- in_cpu_data, in_cpu_data_empty, out_cpu_data_rd, in_cpu_valid, in_cpu_valid_empty, out_cpu_valid_rd: same as the port set, for the CPU source
- in_arb_en  in  2  source enable; bit0 port, bit1 cpu
- in_arb_free_count  in  6  free buffer IDs downstream
- out_arb_data  out  134  merged data word (registered)
- out_arb_data_wr  out  1  out_arb_data valid
- out_arb_valid  out  1  packet valid flag
- out_arb_valid_wr  out  1  out_arb_valid strobe; coincides with the tail word
- out_port_pkt_cnt  out  16  packets forwarded from port, wraps
- out_cpu_pkt_cnt  out  16  packets forwarded from cpu, wraps

## Operation
- States: IDLE, RD_PORT, RD_CPU, GAP.
- IDLE, request definitions:
  - req_port = ~in_port_valid_empty & in_arb_en[0]
  - req_cpu = ~in_cpu_valid_empty & in_arb_en[1]
  - start allowed only if in_arb_free_count ≥ MIN_FREE (unsigned 6-bit compare).
- IDLE, grant rules:
  - One requester: grant it.
  - Both: grant the source that is not last_grant.
  - last_grant is a 1-bit register, reset to cpu, so the first contention grants port.
  - Granting updates last_grant.
- RD_x, per-cycle behaviour:
  - out_x_data_rd = ~in_x_data_empty.
  - When popping, the word is registered to out_arb_data with out_arb_data_wr=1.
  - When in_x_data_empty=1 mid-packet: no pop, out_arb_data_wr=0, stay in RD_x.
- RD_x, tail handling: when the popped word has [133:132]==2'b10:
  - assert out_x_valid_rd in the same cycle;
  - register out_arb_valid <= in_x_valid and out_arb_valid_wr <= 1;
  - increment out_x_pkt_cnt (wrap 16'hFFFF -> 0);
  - go to GAP.
- GAP: one idle cycle (all strobes 0), then IDLE.
- In_arb_en and in_arb_free_count are sampled only in IDLE. Deasserting them mid-packet does not truncate the packet.
- Dropped packets (valid=0) are still forwarded whole. ibm owns the discard.
- Outside write cycles, out_arb_data = 0. Outside the tail cycle, out_arb_valid and out_arb_valid_wr = 0.
- Reset, any time:
  - state IDLE, last_grant cpu;
  - all outputs 0, both counters 0;
  - a packet in flight is truncated, with no tail or valid emitted.

## Timing
- Grant decided at cycle t in IDLE; first pop at t+1; head word appears on out_arb_data at t+2.
- Steady state: 1 word/cycle while the FIFO is non-empty.
- Tail popped at c:
  - tail word + out_arb_valid_wr at c+1;
  - GAP at c+1, IDLE at c+2;
  - next head out no earlier than c+4, i.e. a minimum 2 idle output cycles between packets.
- Read strobes are combinational from state and empty. Every output-side signal is registered.
- A zero-length packet cannot occur. Head and tail in one word ([133:132]=10 on the first word) ends the packet in a single RD cycle.

## Test plan
- Port only, 4-word packet, valid=1, free_count=10:
  - out_port_data_rd high 4 cycles;
  - out_arb_data_wr high 4 cycles starting 2 cycles after the grant;
  - out_arb_valid_wr=1 with the tail, out_arb_valid=1;
  - out_port_pkt_cnt=1.
- Both sources hold 3 packets each, free_count=10:
  - output order port, cpu, port, cpu, port, cpu;
  - never two words from different sources interleaved;
  - both counters end at 3.
- free_count=1, both requesting, MIN_FREE=2: no grant. Raise free_count to 2 at cycle T: head word out at T+2.
- Port packet of 6 words with in_port_data_empty=1 for 3 cycles after word 2: out_arb_data_wr gaps for 3 cycles, then resumes; tail and valid are still correct.
- CPU packet with valid=0, then in_arb_en=2'b01 while a cpu packet is queued:
  - the first packet is forwarded with out_arb_valid=0;
  - the queued cpu packet is not granted;
  - out_cpu_pkt_cnt=1.
- rst_n low mid-packet (word 3 of 5): all outputs 0 within the same cycle. After release, the next queued packet starts cleanly from IDLE with counters 0.

Source files
------------

// File: rtl/ibm_src_arb.sv
// ibm_src_arb: packet-granular round-robin arbiter that merges the port and CPU
// FWFT FIFO pairs into the single data/valid stream consumed by ibm.
module ibm_src_arb #(
    parameter logic [5:0] MIN_FREE = 6'd2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [133:0] in_port_data,
    input  logic         in_port_data_empty,
    output logic         out_port_data_rd,
    input  logic         in_port_valid,
    input  logic         in_port_valid_empty,
    output logic         out_port_valid_rd,
    input  logic [133:0] in_cpu_data,
    input  logic         in_cpu_data_empty,
    output logic         out_cpu_data_rd,
    input  logic         in_cpu_valid,
    input  logic         in_cpu_valid_empty,
    output logic         out_cpu_valid_rd,
    input  logic [1:0]   in_arb_en,
    input  logic [5:0]   in_arb_free_count,
    output logic [133:0] out_arb_data,
    output logic         out_arb_data_wr,
    output logic         out_arb_valid,
    output logic         out_arb_valid_wr,
    output logic [15:0]  out_port_pkt_cnt,
    output logic [15:0]  out_cpu_pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_PORT = 2'd1,
        RD_CPU  = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam logic SRC_PORT = 1'b0;
    localparam logic SRC_CPU  = 1'b1;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_last_grant;
    logic         w_last_grant_nxt;
    logic         w_req_port;
    logic         w_req_cpu;
    logic         w_free_ok;
    logic         w_pop;
    logic         w_tail;
    logic [133:0] w_word;
    logic         w_word_valid;

    logic [133:0] r_data;
    logic         r_data_wr;
    logic         r_valid;
    logic         r_valid_wr;
    logic [15:0]  r_port_cnt;
    logic [15:0]  r_cpu_cnt;

    assign w_req_port = ~in_port_valid_empty & in_arb_en[0];
    assign w_req_cpu  = ~in_cpu_valid_empty & in_arb_en[1];
    assign w_free_ok  = (in_arb_free_count >= MIN_FREE);

    // Next state, grant choice and combinational FIFO read strobes
    always_comb begin
        w_state_nxt       = r_state;
        w_last_grant_nxt  = r_last_grant;
        out_port_data_rd  = 1'b0;
        out_port_valid_rd = 1'b0;
        out_cpu_data_rd   = 1'b0;
        out_cpu_valid_rd  = 1'b0;
        w_pop             = 1'b0;
        w_tail            = 1'b0;
        w_word            = 134'd0;
        w_word_valid      = 1'b0;
        case (r_state)
            IDLE: begin
                // A lone requester wins; on contention the one not served last wins.
                if (w_free_ok && w_req_port && (!w_req_cpu || r_last_grant == SRC_CPU)) begin
                    w_state_nxt      = RD_PORT;
                    w_last_grant_nxt = SRC_PORT;
                end else if (w_free_ok && w_req_cpu) begin
                    w_state_nxt      = RD_CPU;
                    w_last_grant_nxt = SRC_CPU;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RD_PORT: begin
                out_port_data_rd = ~in_port_data_empty;
                w_pop            = ~in_port_data_empty;
                w_word           = in_port_data;
                w_word_valid     = in_port_valid;
                if (!in_port_data_empty && in_port_data[133:132] == 2'b10) begin
                    w_tail            = 1'b1;
                    out_port_valid_rd = 1'b1;
                    w_state_nxt       = GAP;
                end else begin
                    w_state_nxt = RD_PORT;
                end
            end
            RD_CPU: begin
                out_cpu_data_rd = ~in_cpu_data_empty;
                w_pop           = ~in_cpu_data_empty;
                w_word          = in_cpu_data;
                w_word_valid    = in_cpu_valid;
                if (!in_cpu_data_empty && in_cpu_data[133:132] == 2'b10) begin
                    w_tail           = 1'b1;
                    out_cpu_valid_rd = 1'b1;
                    w_state_nxt      = GAP;
                end else begin
                    w_state_nxt = RD_CPU;
                end
            end
            GAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, grant history, registered output stage and packet counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= SRC_CPU;
            r_data       <= 134'd0;
            r_data_wr    <= 1'b0;
            r_valid      <= 1'b0;
            r_valid_wr   <= 1'b0;
            r_port_cnt   <= 16'd0;
            r_cpu_cnt    <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_data       <= w_pop ? w_word : 134'd0;
            r_data_wr    <= w_pop;
            r_valid      <= w_tail ? w_word_valid : 1'b0;
            r_valid_wr   <= w_tail;
            if (w_tail && r_state == RD_PORT) begin
                r_port_cnt <= r_port_cnt + 16'd1;
            end
            if (w_tail && r_state == RD_CPU) begin
                r_cpu_cnt <= r_cpu_cnt + 16'd1;
            end
        end
    end

    assign out_arb_data     = r_data;
    assign out_arb_data_wr  = r_data_wr;
    assign out_arb_valid    = r_valid;
    assign out_arb_valid_wr = r_valid_wr;
    assign out_port_pkt_cnt = r_port_cnt;
    assign out_cpu_pkt_cnt  = r_cpu_cnt;

endmodule

// File: tb/tb_ibm_src_arb.sv
// Bench for ibm_src_arb: FIFO models feed both sources; a packet-level
// round-robin model predicts the exact merged word stream and counters.
module tb_ibm_src_arb;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   arb_en = 2'b00;
    logic [5:0]   free_cnt = 6'd10;
    logic         port_stall = 1'b0;
    logic         cpu_stall = 1'b0;

    logic [133:0] p_head = 134'd0;
    logic         p_dempty = 1'b1;
    logic         p_vhead = 1'b0;
    logic         p_vempty = 1'b1;
    logic [133:0] c_head = 134'd0;
    logic         c_dempty = 1'b1;
    logic         c_vhead = 1'b0;
    logic         c_vempty = 1'b1;

    logic         out_port_data_rd, out_port_valid_rd, out_cpu_data_rd, out_cpu_valid_rd;
    logic [133:0] out_arb_data;
    logic         out_arb_data_wr, out_arb_valid, out_arb_valid_wr;
    logic [15:0]  out_port_pkt_cnt, out_cpu_pkt_cnt;

    // FIFO contents seen by the DUT
    logic [133:0] pq_data[$];
    bit           pq_valid[$];
    logic [133:0] cq_data[$];
    bit           cq_valid[$];

    // Reference model: pending packets per source and the expected output stream
    logic [133:0] pm_words_p[$];
    int           pm_len_p[$];
    bit           pm_vld_p[$];
    logic [133:0] pm_words_c[$];
    int           pm_len_c[$];
    bit           pm_vld_c[$];
    logic [133:0] exp_words[$];
    bit           exp_vld[$];
    bit           m_last_cpu = 1'b1;
    logic [15:0]  exp_pcnt = 16'd0;
    logic [15:0]  exp_ccnt = 16'd0;

    int total = 0;
    int bad = 0;
    int since = 99;
    bit in_pkt = 1'b0;

    always #5 clk = ~clk;

    ibm_src_arb #(.MIN_FREE(6'd2)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_port_data        (p_head),
        .in_port_data_empty  (p_dempty | port_stall),
        .out_port_data_rd    (out_port_data_rd),
        .in_port_valid       (p_vhead),
        .in_port_valid_empty (p_vempty),
        .out_port_valid_rd   (out_port_valid_rd),
        .in_cpu_data         (c_head),
        .in_cpu_data_empty   (c_dempty | cpu_stall),
        .out_cpu_data_rd     (out_cpu_data_rd),
        .in_cpu_valid        (c_vhead),
        .in_cpu_valid_empty  (c_vempty),
        .out_cpu_valid_rd    (out_cpu_valid_rd),
        .in_arb_en           (arb_en),
        .in_arb_free_count   (free_cnt),
        .out_arb_data        (out_arb_data),
        .out_arb_data_wr     (out_arb_data_wr),
        .out_arb_valid       (out_arb_valid),
        .out_arb_valid_wr    (out_arb_valid_wr),
        .out_port_pkt_cnt    (out_port_pkt_cnt),
        .out_cpu_pkt_cnt     (out_cpu_pkt_cnt)
    );

    task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // FWFT FIFO behaviour: pop on read strobe, head registered after the edge
    always @(posedge clk) begin
        if (out_port_data_rd && pq_data.size() > 0) void'(pq_data.pop_front());
        if (out_port_valid_rd && pq_valid.size() > 0) void'(pq_valid.pop_front());
        if (out_cpu_data_rd && cq_data.size() > 0) void'(cq_data.pop_front());
        if (out_cpu_valid_rd && cq_valid.size() > 0) void'(cq_valid.pop_front());
        p_head   <= (pq_data.size() > 0) ? pq_data[0] : 134'd0;
        p_dempty <= (pq_data.size() == 0);
        p_vhead  <= (pq_valid.size() > 0) ? pq_valid[0] : 1'b0;
        p_vempty <= (pq_valid.size() == 0);
        c_head   <= (cq_data.size() > 0) ? cq_data[0] : 134'd0;
        c_dempty <= (cq_data.size() == 0);
        c_vhead  <= (cq_valid.size() > 0) ? cq_valid[0] : 1'b0;
        c_vempty <= (cq_valid.size() == 0);
    end

    // Output monitor: exact word stream, valid flag, idle gap, zero-when-idle
    always @(negedge clk) begin
        logic [133:0] ew;
        bit ev;
        if (!rst_n) begin
            since  = 99;
            in_pkt = 1'b0;
        end else begin
            check("dual_rd", 134'(out_port_data_rd & out_cpu_data_rd), 134'd0);
            if (out_arb_data_wr) begin
                if (!in_pkt) begin
                    check("min_gap", 134'(since >= 2), 134'd1);
                    in_pkt = 1'b1;
                end
                check("word_expected", 134'(exp_words.size() > 0), 134'd1);
                if (exp_words.size() > 0) begin
                    ew = exp_words.pop_front();
                    check("data", out_arb_data, ew);
                end
            end else begin
                check("data_idle_zero", out_arb_data, 134'd0);
                since++;
            end
            if (out_arb_valid_wr) begin
                check("vwr_on_tail", 134'(out_arb_data_wr & (out_arb_data[133:132] == 2'b10)), 134'd1);
                check("vld_expected", 134'(exp_vld.size() > 0), 134'd1);
                if (exp_vld.size() > 0) begin
                    ev = exp_vld.pop_front();
                    check("valid", 134'(out_arb_valid), 134'(ev));
                end
                in_pkt = 1'b0;
                since  = 0;
            end else begin
                check("valid_idle_zero", 134'(out_arb_valid), 134'd0);
            end
        end
    end

    task automatic load_pkt(input bit src, input int len, input bit vld);
        logic [133:0] w;
        logic [1:0] tg;
        for (int i = 0; i < len; i++) begin
            if (len == 1) tg = 2'b10;
            else if (i == 0) tg = 2'b01;
            else if (i == len - 1) tg = 2'b10;
            else tg = 2'b11;
            w = {tg, $urandom(), $urandom(), $urandom(), $urandom(), 4'(i)};
            if (!src) begin
                pq_data.push_back(w);
                pm_words_p.push_back(w);
            end else begin
                cq_data.push_back(w);
                pm_words_c.push_back(w);
            end
        end
        if (!src) begin
            pq_valid.push_back(vld);
            pm_vld_p.push_back(vld);
            pm_len_p.push_back(len);
        end else begin
            cq_valid.push_back(vld);
            pm_vld_c.push_back(vld);
            pm_len_c.push_back(len);
        end
    endtask

    // Whole packets of enabled sources, alternating while both have one queued
    function automatic void model_drain(input logic [1:0] en);
        int np;
        int nc;
        int len;
        bit take_port;
        np = en[0] ? pm_len_p.size() : 0;
        nc = en[1] ? pm_len_c.size() : 0;
        while (np > 0 || nc > 0) begin
            if (np > 0 && nc > 0) take_port = m_last_cpu;
            else take_port = (np > 0);
            if (take_port) begin
                len = pm_len_p.pop_front();
                repeat (len) exp_words.push_back(pm_words_p.pop_front());
                exp_vld.push_back(pm_vld_p.pop_front());
                exp_pcnt++;
                np--;
                m_last_cpu = 1'b0;
            end else begin
                len = pm_len_c.pop_front();
                repeat (len) exp_words.push_back(pm_words_c.pop_front());
                exp_vld.push_back(pm_vld_c.pop_front());
                exp_ccnt++;
                nc--;
                m_last_cpu = 1'b1;
            end
        end
    endfunction

    task automatic wait_drain(input bit rnd);
        int k;
        k = 0;
        while ((exp_words.size() != 0 || exp_vld.size() != 0) && k < 2000) begin
            @(negedge clk);
            if (rnd) begin
                port_stall = ($urandom_range(0, 3) == 0);
                cpu_stall  = ($urandom_range(0, 3) == 0);
            end
            k++;
        end
        port_stall = 1'b0;
        cpu_stall  = 1'b0;
        check("drain_timeout", 134'(k < 2000), 134'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_port_cnt"}, 134'(out_port_pkt_cnt), 134'(exp_pcnt));
        check({tag, "_cpu_cnt"}, 134'(out_cpu_pkt_cnt), 134'(exp_ccnt));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"}, out_arb_data, 134'd0);
        check({tag, "_strobes"}, 134'({out_arb_data_wr, out_arb_valid, out_arb_valid_wr,
              out_port_data_rd, out_port_valid_rd, out_cpu_data_rd, out_cpu_valid_rd}), 134'd0);
        check({tag, "_port_cnt"}, 134'(out_port_pkt_cnt), 134'd0);
        check({tag, "_cpu_cnt"}, 134'(out_cpu_pkt_cnt), 134'd0);
    endtask

    initial begin
        int rdc, wrc, frd, fwr, pops, seen, k;
        bit port_first;
        logic [133:0] w;

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("post_reset");

        // Three packets per source: strict alternation starting with port
        for (int i = 0; i < 3; i++) begin
            load_pkt(1'b0, 3, 1'b1);
            load_pkt(1'b1, 3, 1'b1);
        end
        model_drain(2'b11);
        arb_en = 2'b11;
        wait_drain(1'b0);
        check_counts("both3");

        // Port-only 4-word packet: read/write windows and grant latency
        arb_en = 2'b00;
        load_pkt(1'b0, 4, 1'b1);
        model_drain(2'b01);
        arb_en = 2'b01;
        rdc = 0; wrc = 0; frd = -1; fwr = -1;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (out_port_data_rd) begin
                rdc++;
                if (frd < 0) frd = j;
            end
            if (out_arb_data_wr) begin
                wrc++;
                if (fwr < 0) fwr = j;
            end
        end
        check("p4_rd_cycles", 134'(rdc), 134'd4);
        check("p4_wr_cycles", 134'(wrc), 134'd4);
        check("p4_rd_to_wr", 134'(fwr - frd), 134'd1);
        check_counts("p4");

        // Free count below threshold blocks the start; reaching it releases
        arb_en = 2'b00;
        free_cnt = 6'd1;
        load_pkt(1'b0, 2, 1'b1);
        load_pkt(1'b1, 2, 1'b0);
        port_first = m_last_cpu;
        model_drain(2'b11);
        arb_en = 2'b11;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("free_block", 134'({out_port_data_rd, out_cpu_data_rd, out_arb_data_wr}), 134'd0);
        end
        free_cnt = 6'd2;
        @(negedge clk);
        check("free_first_pop", 134'({out_port_data_rd, out_cpu_data_rd}),
              port_first ? 134'd2 : 134'd1);
        check("free_no_wr_yet", 134'(out_arb_data_wr), 134'd0);
        @(negedge clk);
        check("free_head_out", 134'(out_arb_data_wr), 134'd1);
        wait_drain(1'b0);
        free_cnt = 6'd10;
        check_counts("free");

        // Data FIFO runs empty mid-packet for three cycles
        arb_en = 2'b00;
        load_pkt(1'b0, 6, 1'b1);
        model_drain(2'b01);
        arb_en = 2'b01;
        pops = 0; k = 0;
        while (pops < 2 && k < 40) begin
            @(negedge clk);
            if (out_port_data_rd) pops++;
            k++;
        end
        check("stall_reach", 134'(pops), 134'd2);
        @(negedge clk);
        port_stall = 1'b1;
        #1;
        check("stall_rd_low", 134'(out_port_data_rd), 134'd0);
        repeat (3) begin
            @(negedge clk);
            check("stall_wr_gap", 134'(out_arb_data_wr), 134'd0);
        end
        port_stall = 1'b0;
        wait_drain(1'b0);
        check_counts("stall");

        // Dropped cpu packet is forwarded; disabled cpu source is not granted
        arb_en = 2'b00;
        load_pkt(1'b1, 3, 1'b0);
        model_drain(2'b10);
        arb_en = 2'b10;
        wait_drain(1'b0);
        check_counts("drop");
        arb_en = 2'b01;
        load_pkt(1'b1, 2, 1'b1);
        model_drain(2'b01);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            check("cpu_disabled", 134'(out_cpu_data_rd), 134'd0);
        end
        check_counts("disabled");

        // Reset in the middle of a 5-word port packet
        load_pkt(1'b0, 5, 1'b1);
        model_drain(2'b01);
        seen = 0; k = 0;
        while (seen < 3 && k < 60) begin
            @(negedge clk);
            if (out_arb_data_wr) seen++;
            k++;
        end
        check("rst_reach", 134'(seen), 134'd3);
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        while (pq_data.size() > 0) begin
            w = pq_data.pop_front();
            if (w[133:132] == 2'b10) break;
        end
        if (pq_valid.size() > 0) void'(pq_valid.pop_front());
        exp_words.delete();
        exp_vld.delete();
        m_last_cpu = 1'b1;
        exp_pcnt = 16'd0;
        exp_ccnt = 16'd0;
        repeat (2) @(negedge clk);
        check_zero("held_reset");
        rst_n = 1'b1;
        load_pkt(1'b0, 3, 1'b1);
        model_drain(2'b01);
        wait_drain(1'b0);
        check_counts("after_reset");

        // Random rounds with random lengths, flags, free counts and FIFO bubbles
        for (int r = 0; r < 8; r++) begin
            arb_en = 2'b00;
            for (int i = 0; i < int'($urandom_range(0, 3)); i++)
                load_pkt(1'b0, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < int'($urandom_range(0, 3)); i++)
                load_pkt(1'b1, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
            free_cnt = 6'($urandom_range(2, 63));
            model_drain(2'b11);
            arb_en = 2'b11;
            wait_drain(1'b1);
            check_counts("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
